// File: rtl/minc_pkg.sv
// Shared definitions for the minc core and its program loader.
package minc_pkg;

    localparam int         MINC_WORD_W   = 15;
    localparam int         MINC_ADDR_W   = 8;
    localparam logic [7:0] MINC_LOAD_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        SUM,
        RUN
    } loader_state_t;

endpackage

// File: rtl/minc_loader_if.sv
// Byte stream in and instruction memory write port out, bundled for the loader.
// slave = loader side, master = byte source / memory observer side.
interface minc_loader_if
    import minc_pkg::*;
#(
    parameter int ADDR_W = MINC_ADDR_W,
    parameter int WORD_W = MINC_WORD_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/minc_loader.sv
// Program loader for the minc core: parses HDR/LEN/words/SUM frames,
// writes 15-bit words into instruction memory from address 0 upward and
// releases the core only after a frame with a matching checksum.
//
// state | meaning
// IDLE  | waiting for header byte, other bytes dropped
// LEN   | next byte is the word count (0 = 256)
// HI    | expecting high byte of a word (bit 7 must be 0)
// LO    | expecting low byte; completes and writes the word
// SUM   | expecting checksum byte
// RUN   | frame accepted, core running; header byte starts a reload
module minc_loader
    import minc_pkg::*;
#(
    parameter int         ADDR_W = MINC_ADDR_W,
    parameter int         WORD_W = MINC_WORD_W,
    parameter logic [7:0] HDR    = MINC_LOAD_HDR
) (
    input  logic              CLK,
    input  logic              RESET,
    minc_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    loader_state_t state;
    logic [8:0]    remaining;
    logic [7:0]    checksum;
    logic [6:0]    word_hi;
    logic          xfer;
    logic [WORD_W-1:0] word_next;

    // Byte handshake and the word assembled from the latched high part.
    always_comb begin
        xfer      = bus.rx_valid & bus.rx_ready;
        word_next = {word_hi, bus.rx_data};
    end

    // Frame parser, counters and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            remaining    <= '0;
            checksum     <= '0;
            word_hi      <= '0;
            bus.rx_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.rx_ready <= 1'b1;
            bus.wr_en    <= 1'b0;
            // Address moves on in the cycle after the strobe so it is stable while wr_en is high.
            if (bus.wr_en) begin
                bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
            end
            if (xfer) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == HDR) begin
                            state       <= LEN;
                            err         <= 1'b0;
                            checksum    <= '0;
                            bus.wr_addr <= '0;
                        end
                    end
                    LEN: begin
                        remaining <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                        state     <= HI;
                    end
                    HI: begin
                        if (bus.rx_data[7]) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            word_hi  <= bus.rx_data[6:0];
                            checksum <= checksum + bus.rx_data;
                            state    <= LO;
                        end
                    end
                    LO: begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_data <= word_next;
                        checksum    <= checksum + bus.rx_data;
                        remaining   <= remaining - 9'd1;
                        state       <= (remaining == 9'd1) ? SUM : HI;
                    end
                    SUM: begin
                        if (bus.rx_data == checksum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    RUN: begin
                        if (bus.rx_data == HDR) begin
                            cpu_hold    <= 1'b1;
                            done        <= 1'b0;
                            err         <= 1'b0;
                            checksum    <= '0;
                            bus.wr_addr <= '0;
                            state       <= LEN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minc_loader.sv
// Directed bench for minc_loader: frames are driven byte by byte and
// outputs/write log compared against hand-computed values.
module tb_minc_loader;
    import minc_pkg::*;

    logic clk;
    logic reset;
    logic cpu_hold;
    logic done;
    logic err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  log_addr[$];
    logic [14:0] log_data[$];

    minc_loader_if bus ();

    minc_loader dut (
        .CLK      (clk),
        .RESET    (reset),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_err"},      32'(err),          32'd0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);

        // Good 2-word frame with a stall in the middle of the first word.
        clear_log();
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        idle(3);
        chk("stall_no_wr", 32'(bus.wr_en), 32'd0);
        send(8'h05);
        chk("w0_en",   32'(bus.wr_en),   32'd1);
        chk("w0_addr", 32'(bus.wr_addr), 32'd0);
        chk("w0_data", 32'(bus.wr_data), 32'h1005);
        send(8'h00);
        chk("w0_en_drop", 32'(bus.wr_en),   32'd0);
        chk("addr_adv",   32'(bus.wr_addr), 32'd1);
        send(8'hFF);
        chk("w1_en",   32'(bus.wr_en),   32'd1);
        chk("w1_addr", 32'(bus.wr_addr), 32'd1);
        chk("w1_data", 32'(bus.wr_data), 32'h00FF);
        chk("pre_sum_done", 32'(done),     32'd0);
        chk("pre_sum_hold", 32'(cpu_hold), 32'd1);
        send(8'h14);
        chk("good_done", 32'(done),     32'd1);
        chk("good_hold", 32'(cpu_hold), 32'd0);
        chk("good_err",  32'(err),      32'd0);
        idle(2);
        chk("good_done_held", 32'(done), 32'd1);
        chk("good_nwr",  32'(log_addr.size()), 32'd2);

        // Reload from RUN with a bad checksum.
        clear_log();
        send(8'hA5);
        chk("reload_hold", 32'(cpu_hold),    32'd1);
        chk("reload_done", 32'(done),        32'd0);
        chk("reload_addr", 32'(bus.wr_addr), 32'd0);
        send(8'h02);
        send(8'h10);
        send(8'h05);
        send(8'h00);
        send(8'hFF);
        send(8'h15);
        chk("bad_err",  32'(err),      32'd1);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        chk("bad_done", 32'(done),     32'd0);
        idle(1);
        chk("bad_nwr", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("bad_a1", 32'(log_addr[1]), 32'd1);
            chk("bad_d1", 32'(log_data[1]), 32'h00FF);
        end

        // High byte with bit 7 set, then a good frame.
        clear_log();
        send(8'hA5);
        chk("hdr_clr_err", 32'(err), 32'd0);
        send(8'h01);
        send(8'h80);
        chk("bit7_err", 32'(err), 32'd1);
        send(8'h00);
        chk("bit7_err_sticky", 32'(err), 32'd1);
        idle(1);
        chk("bit7_nwr", 32'(log_addr.size()), 32'd0);
        send(8'hA5);
        chk("recover_err", 32'(err), 32'd0);
        send(8'h01);
        send(8'h00);
        send(8'h07);
        send(8'h07);
        chk("recover_done", 32'(done),     32'd1);
        chk("recover_hold", 32'(cpu_hold), 32'd0);
        idle(1);
        chk("recover_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("recover_a", 32'(log_addr[0]), 32'd0);
            chk("recover_d", 32'(log_data[0]), 32'h0007);
        end

        // Full 256-word frame, word i = i; sum of 0..255 = 0x7F80 -> 0x80.
        clear_log();
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'h00);
            send(8'(i));
        end
        send(8'h80);
        chk("full_done", 32'(done),     32'd1);
        chk("full_hold", 32'(cpu_hold), 32'd0);
        idle(1);
        chk("full_nwr",  32'(log_addr.size()), 32'd256);
        chk("full_wrap", 32'(bus.wr_addr),     32'd0);
        if (log_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("full_a%0d", i), 32'(log_addr[i]), 32'(i));
                chk($sformatf("full_d%0d", i), 32'(log_data[i]), 32'(i));
            end
        end

        // RUN: ignore non-header byte, then reload.
        clear_log();
        send(8'h3C);
        chk("run_ign_done", 32'(done),     32'd1);
        chk("run_ign_hold", 32'(cpu_hold), 32'd0);
        send(8'hA5);
        chk("run_rl_hold", 32'(cpu_hold), 32'd1);
        chk("run_rl_done", 32'(done),     32'd0);
        send(8'h01);
        send(8'h00);
        send(8'h07);
        send(8'h07);
        chk("run_rl_fin", 32'(done), 32'd1);
        idle(1);
        chk("run_rl_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("run_rl_a", 32'(log_addr[0]), 32'd0);
            chk("run_rl_d", 32'(log_data[0]), 32'h0007);
        end

        // Reset in the middle of a frame.
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        send(8'h05);
        send(8'h00);
        chk("mid_addr", 32'(bus.wr_addr), 32'd1);
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_log();
        send(8'h12);
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h46);
        chk("post_rst_done", 32'(done), 32'd1);
        idle(1);
        chk("post_rst_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("post_rst_a", 32'(log_addr[0]), 32'd0);
            chk("post_rst_d", 32'(log_data[0]), 32'h1234);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
